fifo_axis_packer: RTL and testbench
===================================

FIFO_AXIS_PACKER -- requirements
Module: fifo_axis_packer

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 8, meaning the number of output bytes per beat (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port nReset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port fifo_empty_n, input, 1 bit: upstream byte FIFO holds data.
REQ-005 SHALL have port fifo_read, output, 1 bit: pops the FIFO in the same cycle.
REQ-006 SHALL have port fifo_dout, input, 9 bits: [7:0] is the byte, [8] is the last-byte-of-packet flag; it is valid whenever fifo_empty_n=1 (show-ahead).
REQ-007 SHALL have port m_axis_tdata, output, DATA_BYTES*8 bits: packed beat data.
REQ-008 SHALL have port m_axis_tkeep, output, DATA_BYTES bits: byte enables.
REQ-009 SHALL have port m_axis_tlast, output, 1 bit: final beat of the packet.
REQ-010 SHALL have port m_axis_tvalid, output, 1 bit: beat valid.
REQ-011 SHALL have port m_axis_tready, input, 1 bit: downstream accepts the beat.
REQ-012 SHALL have port pkt_count, output, 32 bits: count of packets emitted.

Function
REQ-013 SHALL consume one byte on every cycle where fifo_read=1; fifo_read SHALL equal fifo_empty_n AND (state==ACC OR xfer).
REQ-014 SHALL implement an accumulator FSM with two states: ACC (collecting bytes) and HOLD (word complete, waiting for the output register).
REQ-015 SHALL place the k-th byte of a word in lane k, tdata[8k+7:8k], with lane 0 first (little-endian); the lane counter SHALL run 0..DATA_BYTES-1.
REQ-016 SHALL go from ACC to HOLD when the consumed byte has flag[8]=1 or fills lane DATA_BYTES-1; the counter SHALL wrap to 0.
REQ-017 SHALL define xfer = (state==HOLD) AND (m_axis_tvalid==0 OR m_axis_tready==1).
REQ-018 On xfer, SHALL copy the accumulator into the output register and set m_axis_tvalid=1.
REQ-019 On xfer, m_axis_tkeep SHALL contain contiguous ones from lane 0 up to the highest filled lane.
REQ-020 On xfer, m_axis_tlast SHALL equal the flag of the final byte; the FSM SHALL return to ACC.
REQ-021 A byte consumed in the same cycle as xfer SHALL land in lane 0 of the new word; sustained throughput SHALL be one byte per cycle.
REQ-022 Unfilled lanes of m_axis_tdata SHALL be 0.
REQ-023 While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata, m_axis_tkeep and m_axis_tlast SHALL hold stable.
REQ-024 m_axis_tvalid SHALL clear after a handshake unless a new xfer occurs in the same cycle.
REQ-025 Latency: a word-completing byte consumed in cycle N SHALL appear on the outputs in cycle N+2 when the output register is free.
REQ-026 pkt_count SHALL increment by 1 on each handshake with m_axis_tlast=1, wrapping from 2^32-1 to 0.
REQ-027 A packet of exactly DATA_BYTES bytes SHALL produce one beat with all keep bits set and tlast=1; no empty beat SHALL follow it.

Reset
REQ-028 While nReset=0, SHALL drive fifo_read=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, pkt_count=0, with state=ACC and lane counter=0.
REQ-029 Reset asserted mid-word or mid-packet SHALL discard the partial accumulator without emitting a beat.

Structure
REQ-030 The shared package fifo_axis_pkg SHALL hold the FSM state encoding (ACC, HOLD), the byte-plus-flag width (9), and the lane-index width function.
REQ-031 The output register and its valid/ready hold logic SHALL be one sub-module, fifo_axis_outreg.

Verification
REQ-032 With DATA_BYTES=8 and tready=1, a 3-byte packet 0x11,0x22,0x33(last) SHALL yield tdata=0x0000000000332211, tkeep=0x07, tlast=1, and pkt_count=1.
REQ-033 A 10-byte packet 0x01..0x0A with tready=1 SHALL yield beat 1 = 0x0807060504030201 with keep 0xFF and tlast=0, then beat 2 = 0x0A09 with keep 0x03 and tlast=1.
REQ-034 An 8-byte packet SHALL yield exactly one beat with keep=0xFF and tlast=1; fifo_read SHALL go high in the same cycle as the following packet's first byte.
REQ-035 Continuous FIFO data with tready held low for 20 cycles SHALL give exactly 16 pops; tdata/tkeep SHALL stay stable; after tready rises, no bytes SHALL be lost or duplicated.
REQ-036 nReset pulsed low after 5 of 8 bytes SHALL give no output beat; the next packet 0xAA(last) SHALL yield tdata=0xAA, keep=0x01, tlast=1.
REQ-037 With pkt_count preloaded via 2^32-1 packets (or forced), one more packet SHALL wrap pkt_count to 0.

Source files
------------

// File: rtl/fifo_axis_pkg.sv
// Shared types and sizing for the byte-FIFO to AXI-Stream packer.
package fifo_axis_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int BYTE_FLAG_W = 9;

    function automatic int lane_idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_axis_outreg.sv
// AXI-Stream output register: loads a finished word, counts tlast handshakes; 1-cycle latency.
// Contents hold while tvalid && !tready; the packer only loads when the register is free or draining.
module fifo_axis_outreg #(
    parameter int DATA_BYTES = 8
) (
    input  logic                    clk,
    input  logic                    nReset,
    input  logic                    load,
    input  logic [DATA_BYTES*8-1:0] ld_data,
    input  logic [DATA_BYTES-1:0]   ld_keep,
    input  logic                    ld_last,
    output logic [DATA_BYTES*8-1:0] m_axis_tdata,
    output logic [DATA_BYTES-1:0]   m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [31:0]             pkt_count
);

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            pkt_count     <= '0;
        end else begin
            if (load) begin
                m_axis_tdata  <= ld_data;
                m_axis_tkeep  <= ld_keep;
                m_axis_tlast  <= ld_last;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
                pkt_count <= pkt_count + 32'd1;
        end
    end

endmodule

// File: rtl/fifo_axis_packer.sv
// Packs show-ahead byte FIFO entries into DATA_BYTES-wide AXI-Stream beats; word-completing byte reaches outputs 2 cycles later.
// Stops popping while a full word waits for a stalled output register; 1 byte/cycle when tready keeps up.
module fifo_axis_packer
    import fifo_axis_pkg::*;
#(
    parameter int DATA_BYTES = 8
) (
    input  logic                    clk,
    input  logic                    nReset,
    input  logic                    fifo_empty_n,
    output logic                    fifo_read,
    input  logic [BYTE_FLAG_W-1:0]  fifo_dout,
    output logic [DATA_BYTES*8-1:0] m_axis_tdata,
    output logic [DATA_BYTES-1:0]   m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [31:0]             pkt_count
);

    localparam int LW = lane_idx_w(DATA_BYTES);

    state_t                  state;
    logic [LW-1:0]           lane_cnt;
    logic [DATA_BYTES*8-1:0] acc_data;
    logic [DATA_BYTES-1:0]   acc_keep;
    logic                    acc_last;
    logic                    xfer;

    assign xfer      = (state == HOLD) && (!m_axis_tvalid || m_axis_tready);
    assign fifo_read = nReset && fifo_empty_n && ((state == ACC) || xfer);

    // lane_cnt is already 0 in HOLD, so a byte popped alongside xfer lands in lane 0
    // while the later per-lane write overrides the accumulator clear.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state    <= ACC;
            lane_cnt <= '0;
            acc_data <= '0;
            acc_keep <= '0;
            acc_last <= 1'b0;
        end else begin
            if (xfer) begin
                state    <= ACC;
                acc_data <= '0;
                acc_keep <= '0;
                acc_last <= 1'b0;
            end
            if (fifo_read) begin
                acc_data[8*int'(lane_cnt) +: 8] <= fifo_dout[7:0];
                acc_keep[lane_cnt]              <= 1'b1;
                acc_last                        <= fifo_dout[8];
                if (fifo_dout[8] || lane_cnt == LW'(DATA_BYTES-1)) begin
                    state    <= HOLD;
                    lane_cnt <= '0;
                end else begin
                    lane_cnt <= lane_cnt + LW'(1);
                end
            end
        end
    end

    fifo_axis_outreg #(.DATA_BYTES(DATA_BYTES)) u_outreg (
        .clk           (clk),
        .nReset        (nReset),
        .load          (xfer),
        .ld_data       (acc_data),
        .ld_keep       (acc_keep),
        .ld_last       (acc_last),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .pkt_count     (pkt_count)
    );

endmodule

// File: tb/tb_fifo_axis_packer.sv
// Bench for fifo_axis_packer with DATA_BYTES=8: FIFO model, beat scoreboard, vector table, corner sequences.
module tb_fifo_axis_packer;

    localparam int DB = 8;

    typedef struct packed {
        logic [DB*8-1:0] data;
        logic [DB-1:0]   keep;
        logic            last;
    } beat_t;

    typedef struct {
        int              len;
        int              start;
        int              stp;
        logic [DB*8-1:0] d0;
        logic [DB-1:0]   k0;
        logic            l0;
        int              beats;
    } vec_t;

    logic            clk = 1'b0;
    logic            nReset;
    logic            fifo_empty_n;
    logic            fifo_read;
    logic [8:0]      fifo_dout;
    logic [DB*8-1:0] m_axis_tdata;
    logic [DB-1:0]   m_axis_tkeep;
    logic            m_axis_tlast;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic [31:0]     pkt_count;

    fifo_axis_packer #(.DATA_BYTES(DB)) dut (
        .clk           (clk),
        .nReset        (nReset),
        .fifo_empty_n  (fifo_empty_n),
        .fifo_read     (fifo_read),
        .fifo_dout     (fifo_dout),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .pkt_count     (pkt_count)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         n_pops = 0;
    int         cyc = 0;
    int         pop_cyc = 0;
    int         rise_cyc = -1;
    logic       prev_vld = 1'b0;
    logic       rdy_drive = 1'b1;
    logic [31:0] exp_pkts = 0;
    logic [8:0] src_q[$];
    beat_t      exp_q[$];
    beat_t      got_q[$];
    vec_t       vt[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Queue a packet into the FIFO model and push the beats it should produce.
    task automatic send_pkt(input int len, input int start, input int stp, input logic has_last);
        beat_t cur = '0;
        int    lane = 0;
        for (int i = 0; i < len; i++) begin
            logic [7:0] b = 8'(start + stp * i);
            logic       f = has_last && (i == len - 1);
            src_q.push_back({f, b});
            cur.data[8*lane +: 8] = b;
            cur.keep[lane]        = 1'b1;
            cur.last              = f;
            lane++;
            if (lane == DB || f) begin
                exp_q.push_back(cur);
                cur  = '0;
                lane = 0;
            end
        end
        if (has_last) exp_pkts++;
    endtask

    task automatic step();
        beat_t got;
        beat_t exp;
        @(negedge clk);
        m_axis_tready = rdy_drive;
        fifo_empty_n  = (src_q.size() != 0);
        fifo_dout     = fifo_empty_n ? src_q[0] : 9'h000;
        #1;
        if (fifo_read) begin
            void'(src_q.pop_front());
            n_pops++;
            pop_cyc = cyc;
        end
        if (m_axis_tvalid && !prev_vld) rise_cyc = cyc;
        prev_vld = m_axis_tvalid;
        if (m_axis_tvalid && m_axis_tready) begin
            got = '{m_axis_tdata, m_axis_tkeep, m_axis_tlast};
            got_q.push_back(got);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_beat: got data=%h keep=%h last=%b, expected no beat",
                         got.data, got.keep, got.last);
            end else begin
                exp = exp_q.pop_front();
                check("sb_tdata", got.data, exp.data);
                check("sb_tkeep", 64'(got.keep), 64'(exp.keep));
                check("sb_tlast", 64'(got.last), 64'(exp.last));
            end
        end
        cyc++;
    endtask

    task automatic drain(input int max);
        int n = 0;
        rdy_drive = 1'b1;
        while ((exp_q.size() != 0 || src_q.size() != 0) && n < max) begin
            step();
            n++;
        end
        repeat (4) step();
        check("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fifo_read"}, 64'(fifo_read), 64'd0);
        check({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
        check({tag, "_tdata"}, m_axis_tdata, 64'd0);
        check({tag, "_tkeep"}, 64'(m_axis_tkeep), 64'd0);
        check({tag, "_tlast"}, 64'(m_axis_tlast), 64'd0);
        check({tag, "_pkt_count"}, 64'(pkt_count), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{3,  'h11, 'h11, 64'h0000000000332211, 8'h07, 1'b1, 1};
        vt[1] = '{10, 'h01, 1,    64'h0807060504030201, 8'hFF, 1'b0, 2};
        vt[2] = '{8,  'h40, 1,    64'h4746454443424140, 8'hFF, 1'b1, 1};
        vt[3] = '{1,  'hAA, 0,    64'h00000000000000AA, 8'h01, 1'b1, 1};
        vt[4] = '{16, 'h80, 1,    64'h8786858483828180, 8'hFF, 1'b0, 2};
        vt[5] = '{2,  'hF0, 3,    64'h000000000000F3F0, 8'h03, 1'b1, 1};

        // Reset with FIFO showing data: nothing may pop or appear.
        nReset        = 1'b0;
        fifo_empty_n  = 1'b1;
        fifo_dout     = 9'h1FF;
        m_axis_tready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        nReset = 1'b1;
        fifo_empty_n = 1'b0;

        // Completing byte popped in cycle N must be visible in N+2.
        got_q.delete();
        send_pkt(1, 'h5A, 0, 1'b1);
        drain(50);
        check("latency", 64'(rise_cyc - pop_cyc), 64'd2);
        check("latency_pkt_count", 64'(pkt_count), 64'(exp_pkts));

        for (int v = 0; v < 6; v++) begin
            got_q.delete();
            send_pkt(vt[v].len, vt[v].start, vt[v].stp, 1'b1);
            drain(200);
            check("vec_beats", 64'(got_q.size()), 64'(vt[v].beats));
            if (got_q.size() > 0) begin
                check("vec_d0", got_q[0].data, vt[v].d0);
                check("vec_k0", 64'(got_q[0].keep), 64'(vt[v].k0));
                check("vec_l0", 64'(got_q[0].last), 64'(vt[v].l0));
            end
            check("vec_pkt_count", 64'(pkt_count), 64'(exp_pkts));
        end

        // Back-to-back: full-width packet then the next one, popping every cycle.
        got_q.delete();
        n_pops = 0;
        send_pkt(8, 'h60, 1, 1'b1);
        send_pkt(3, 'h70, 1, 1'b1);
        repeat (11) step();
        check("b2b_pops", 64'(n_pops), 64'd11);
        drain(100);
        check("b2b_beats", 64'(got_q.size()), 64'd2);

        // Long stall: FIFO always has data, tready low for 20 cycles.
        begin
            logic [DB*8-1:0] ref_d = '0;
            logic [DB-1:0]   ref_k = '0;
            logic            have_ref = 1'b0;
            logic            stable = 1'b1;
            got_q.delete();
            n_pops = 0;
            rdy_drive = 1'b0;
            send_pkt(40, 'h20, 1, 1'b1);
            for (int i = 0; i < 20; i++) begin
                step();
                if (m_axis_tvalid) begin
                    if (!have_ref) begin
                        ref_d = m_axis_tdata;
                        ref_k = m_axis_tkeep;
                        have_ref = 1'b1;
                    end else if (m_axis_tdata !== ref_d || m_axis_tkeep !== ref_k) begin
                        stable = 1'b0;
                    end
                end
            end
            check("stall_pops", 64'(n_pops), 64'd16);
            check("stall_valid", 64'(have_ref), 64'd1);
            check("stall_stable", 64'(stable), 64'd1);
            drain(200);
            check("stall_beats", 64'(got_q.size()), 64'd5);
        end

        // Reset after 5 bytes of an 8-byte packet: partial word is dropped.
        got_q.delete();
        n_pops = 0;
        send_pkt(5, 'hC0, 1, 1'b0);
        repeat (5) step();
        check("mid_pops", 64'(n_pops), 64'd5);
        @(negedge clk);
        nReset = 1'b0;
        src_q.delete();
        exp_q.delete();
        fifo_empty_n = 1'b1;
        fifo_dout = 9'h0C5;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        nReset = 1'b1;
        fifo_empty_n = 1'b0;
        prev_vld = 1'b0;
        exp_pkts = 0;
        send_pkt(1, 'hAA, 0, 1'b1);
        drain(50);
        check("post_rst_beats", 64'(got_q.size()), 64'd1);
        if (got_q.size() > 0) begin
            check("post_rst_tdata", got_q[0].data, 64'h00000000000000AA);
            check("post_rst_tkeep", 64'(got_q[0].keep), 64'h01);
            check("post_rst_tlast", 64'(got_q[0].last), 64'd1);
        end
        check("post_rst_pkt_count", 64'(pkt_count), 64'd1);

        // Counter wrap from all-ones.
        @(negedge clk);
        force dut.u_outreg.pkt_count = 32'hFFFF_FFFF;
        #1;
        release dut.u_outreg.pkt_count;
        #1;
        check("wrap_preload", 64'(pkt_count), 64'hFFFF_FFFF);
        send_pkt(2, 'h33, 1, 1'b1);
        drain(50);
        check("wrap_pkt_count", 64'(pkt_count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
